// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM initialisation controller.
package ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 16;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Front end for a read-first synchronous RAM: sweeps every word to a fill value
// after reset or on request, then forwards host requests with a one-cycle read response.
module ram_init_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  busy,
    output logic                  clr_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(depth(ADDR_WIDTH) - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [ADDR_WIDTH-1:0] r_last_a;
    logic                  r_clr_done;
    logic                  r_rsp_valid;
    logic                  w_accept;

    assign busy      = (r_state == CLEAR);
    assign req_ready = (r_state == READY);
    assign w_accept  = req_valid & req_ready;
    assign clr_done  = r_clr_done;
    assign rsp_valid = r_rsp_valid;
    // The RAM output register already provides the one-cycle read latency.
    assign rsp_rdata = ram_do;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_we = 1'b0;
        ram_a  = r_last_a;
        ram_di = r_fill;
        if (r_state == CLEAR) begin
            ram_we = 1'b1;
            ram_a  = r_cnt;
            ram_di = r_fill;
        end else if (w_accept) begin
            ram_we = req_we;
            ram_a  = req_addr;
            ram_di = req_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_cnt       <= '0;
            r_fill      <= INIT_VALUE;
            r_last_a    <= '0;
            r_clr_done  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_last_a    <= ram_a;
            r_rsp_valid <= w_accept & ~req_we;
            r_clr_done  <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_state    <= READY;
                        r_clr_done <= 1'b1;
                    end
                end
                READY: begin
                    if (clr_start) begin
                        r_fill  <= clr_value;
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

endmodule

// File: doc/ram_init_ctrl.md
Name: ram_init_ctrl

Overview:
- Front-end controller for a single-port, read-first, synchronous RAM.
- Port contract of that RAM: clk, we, a, di, registered output do; default 7-bit address, 16-bit data.
- After reset, or on request at any later time, sweeps every RAM word to a fill value, so initialization no longer depends on configuration-time contents.
- Outside the sweep, passes host read/write requests to the RAM through a valid/ready handshake and returns read data with a response-valid strobe.

Parameters:
- ADDR_WIDTH, 7, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, RAM data width.
- INIT_VALUE, 0, fill value used by the automatic sweep after reset.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  request a new clear sweep; honoured only in READY.
- clr_value  in  DATA_WIDTH  fill value, sampled when clr_start is honoured.
- busy  out  1  high while sweeping.
- clr_done  out  1  one-cycle pulse after the last sweep write.
- req_valid  in  1  host request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_rdata  out  DATA_WIDTH  read data.
- ram_we  out  1  to RAM we.
- ram_a  out  ADDR_WIDTH  to RAM a.
- ram_di  out  DATA_WIDTH  to RAM di.
- ram_do  in  DATA_WIDTH  from RAM do.

Behaviour:
- States: CLEAR, READY. Reset (rst_n low, asynchronous) forces CLEAR, cnt=0, fill=INIT_VALUE, clr_done=0, rsp_valid=0.
- On rst_n release, the sweep starts at the first clk edge. Reset mid-sweep or mid-read always restarts from address 0 and discards any pending response.
- CLEAR:
  - ram_we=1, ram_a=cnt, ram_di=fill; busy=1, req_ready=0.
  - cnt increments each cycle; exactly DEPTH write cycles.
  - When cnt==DEPTH-1: next state READY, cnt wraps to 0, clr_done=1 for the following cycle.
  - clr_start is ignored in CLEAR.
- READY:
  - busy=0, req_ready=1 (driven only by state, never by req_valid).
  - Accept condition: req_valid & req_ready.
  - On accept, the same cycle drives ram_we=req_we, ram_a=req_addr, ram_di=req_wdata (combinational).
  - With no accept: ram_we=0; ram_a holds the last driven address; ram_di is don't-care.
- Read latency:
  - An accepted read (req_we=0) in cycle N gives rsp_valid=1 in cycle N+1, with rsp_rdata=ram_do.
  - An accepted write produces no response.
  - Back-to-back reads give back-to-back responses: throughput 1 per cycle.
- clr_start in READY:
  - fill<=clr_value, next state CLEAR, cnt=0.
  - A request accepted in the same cycle executes normally. Its read response still appears in cycle N+1, the first CLEAR cycle, carrying pre-clear data.
- rsp_valid and clr_done are registered. All RAM-side outputs are combinational from state, cnt and request inputs.
- No widths change: cnt is ADDR_WIDTH bits, and its wrap from DEPTH-1 to 0 is natural overflow.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum {CLEAR, READY};
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - depth helper function.
- No sub-module needed. The sweep address counter stays inline.
- The RAM is instantiated beside this block by the integrating level, not inside it.

Test Plan:
- Reset sweep: hold rst_n low 3 cycles, release. Required: busy=1 for exactly 128 cycles, ram_we=1 with ram_a 0..127, ram_di=0; clr_done pulses once; req_ready rises the same cycle clr_done is high.
- Write then read: write 0xBEEF to addr 0x05, then read 0x05 next cycle. Required: rsp_valid one cycle after the read, rsp_rdata=0xBEEF; no rsp_valid for the write.
- Streaming reads: reads of addr 0,1,2 on consecutive cycles after writes of 0x1111,0x2222,0x3333. Required: three consecutive rsp_valid cycles in order.
- Runtime clear: clr_start=1 with clr_value=0xA5A5 together with a read of addr 0x05 holding 0xBEEF. Required: rsp_rdata=0xBEEF in the next cycle while busy=1; after clr_done, a read of 0x05 returns 0xA5A5.
- Ignored start plus back-pressure: pulse clr_start at sweep cycle 40 and hold req_valid high throughout. Required: sweep still ends after 128 cycles with the original fill value; no request accepted until READY.
- Reset mid-sweep: assert rst_n low at sweep cycle 60. Required: outputs reset immediately; after release, the sweep restarts at addr 0 and runs a full 128 cycles.
